uart_rx: RTL and testbench

- 8N1 UART receiver; the receive end of the link driven by the team's UART transmitter.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first at bit centres and checks the stop bit.
- Presents each good byte with a one-cycle valid strobe, directly compatible with the transmitter's rx_dv/rx_byte inputs for loopback.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing,
// common to the receiver and the transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 217;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_DATA  = S_DATA,
        ST_STOP  = S_STOP,
        ST_BREAK = S_BREAK
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to
// RESET_VAL so the output starts out at the line's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit validated at mid-bit, data sampled LSB-first at
// bit centres, good bytes flagged with a one-cycle rx_dv, bad stop bits with frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    output logic       rx_active,
    output logic       frame_err
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CW-1:0] HALF_C = CW'(HALF_BIT);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;
    logic          active_q, active_d;
    logic          fe_q, fe_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_serial),
        .q     (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        active_d  = active_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                active_d  = 1'b0;
                if (!rx_s) begin
                    state_d  = ST_START;
                    active_d = 1'b1;
                end
            end

            ST_START: begin
                if (cnt_q < HALF_C) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end
                end
            end

            ST_DATA: begin
                if (cnt_q < LAST_C) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q < LAST_C) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Hold off until the line returns high so a break cannot look like a start bit.
                cnt_d    = '0;
                active_d = 1'b0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
                active_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            active_q  <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            active_q  <= active_d;
            fe_q      <= fe_d;
        end
    end

    assign rx_dv     = dv_q;
    assign rx_byte   = byte_q;
    assign rx_active = active_q;
    assign frame_err = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver at 217 clocks/bit for the timing corner cases,
// one at 16 clocks/bit for a vector table and a random ideal-transmitter loopback.
module tb_uart_rx;

    localparam int CPB_A  = 217;
    localparam int CPB_B  = 16;
    localparam int LAT_A  = 3 + (CPB_A - 1) / 2 + 9 * CPB_A;
    localparam int LAT_B  = 3 + (CPB_B - 1) / 2 + 9 * CPB_B;
    localparam int HALF_A = (CPB_A - 1) / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n_a, rst_n_b;
    logic       rx_a, rx_b;
    logic       rx_dv_a, rx_dv_b;
    logic [7:0] rx_byte_a, rx_byte_b;
    logic       rx_active_a, rx_active_b;
    logic       frame_err_a, frame_err_b;

    uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .rx_serial (rx_a),
        .rx_dv     (rx_dv_a),
        .rx_byte   (rx_byte_a),
        .rx_active (rx_active_a),
        .frame_err (frame_err_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .rx_serial (rx_b),
        .rx_dv     (rx_dv_b),
        .rx_byte   (rx_byte_b),
        .rx_active (rx_active_b),
        .frame_err (frame_err_b)
    );

    int         dva_t[$];
    logic [7:0] dva_b[$];
    int         fea_t[$];
    int         acta_rise[$];
    int         acta_fall[$];
    int         dvb_t[$];
    logic [7:0] dvb_b[$];
    int         feb_t[$];
    logic       act_prev_a = 1'b0;

    // Event recorder: an output registered at edge N is logged with time N.
    always @(negedge clk) begin
        if (rx_dv_a) begin
            dva_t.push_back(cyc);
            dva_b.push_back(rx_byte_a);
        end
        if (frame_err_a) fea_t.push_back(cyc);
        if (rx_active_a && !act_prev_a) acta_rise.push_back(cyc);
        if (!rx_active_a && act_prev_a) acta_fall.push_back(cyc);
        act_prev_a = rx_active_a;
        if (rx_dv_b) begin
            dvb_t.push_back(cyc);
            dvb_b.push_back(rx_byte_b);
        end
        if (frame_err_b) feb_t.push_back(cyc);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic clear_a();
        dva_t.delete(); dva_b.delete(); fea_t.delete();
        acta_rise.delete(); acta_fall.delete();
    endtask

    task automatic clear_b();
        dvb_t.delete(); dvb_b.delete(); feb_t.delete();
    endtask

    // Ideal 8N1 transmitter. Must be called at a negedge; returns at the negedge
    // where the next frame's start bit may be driven. p = edge that captures the
    // start-bit falling edge. The line is left at the stop-bit level.
    task automatic send(input bit sel, input logic [7:0] b, input bit stop_ok, output int p);
        logic [9:0] fr;
        int         cpb;
        fr  = {stop_ok, b, 1'b0};
        cpb = sel ? CPB_B : CPB_A;
        p   = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            if (sel) rx_b = fr[i];
            else     rx_a = fr[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_dv;
        int         exp_fe;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vecs[8];
    int         p, p2;
    int         ps[4];
    logic [7:0] b2b[4];
    logic [7:0] sent[$];
    logic [7:0] rb;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'hC3, 1'b0, 0, 1, 8'h55};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 0, 1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[5] = '{8'h80, 1'b0, 0, 1, 8'hFF};
        vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[7] = '{8'h7E, 1'b1, 1, 0, 8'h7E};
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h01; b2b[3] = 8'h80;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a_dv",     rx_dv_a,     0);
        check("reset_a_byte",   rx_byte_a,   0);
        check("reset_a_active", rx_active_a, 0);
        check("reset_a_ferr",   frame_err_a, 0);
        check("reset_b_byte",   rx_byte_b,   0);
        check("reset_b_active", rx_active_b, 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_a_active", rx_active_a, 0);
        check("idle_a_byte",   rx_byte_a,   0);

        // Single frame 0xA5: exact latency and rx_active window.
        clear_a();
        send(0, 8'hA5, 1'b1, p);
        repeat (CPB_A) @(negedge clk);
        check("a5_dv_count", dva_t.size(), 1);
        if (dva_t.size() > 0) begin
            check("a5_dv_time", dva_t[0], p + LAT_A);
            check("a5_dv_byte", dva_b[0], 8'hA5);
        end
        check("a5_rx_byte",   rx_byte_a,   8'hA5);
        check("a5_ferr_count", fea_t.size(), 0);
        check("a5_active_rises", acta_rise.size(), 1);
        if (acta_rise.size() > 0)
            check("a5_active_rise_window", (acta_rise[0] >= p + 2) && (acta_rise[0] <= p + 3), 1);
        if (acta_fall.size() > 0)
            check("a5_active_fall", acta_fall[0], p + LAT_A);

        // Four frames back-to-back with no idle gap.
        clear_a();
        for (int i = 0; i < 4; i++) send(0, b2b[i], 1'b1, ps[i]);
        repeat (CPB_A) @(negedge clk);
        check("b2b_dv_count", dva_t.size(), 4);
        for (int i = 0; i < 4 && i < dva_t.size(); i++) begin
            check($sformatf("b2b_time_%0d", i), dva_t[i], ps[i] + LAT_A);
            check($sformatf("b2b_byte_%0d", i), dva_b[i], b2b[i]);
            if (i > 0) check($sformatf("b2b_spacing_%0d", i), dva_t[i] - dva_t[i-1], 10 * CPB_A);
        end
        check("b2b_ferr_count", fea_t.size(), 0);

        // 50-cycle low glitch: start bit is rejected at mid-bit.
        clear_a();
        p = cyc + 1;
        rx_a = 1'b0;
        repeat (50) @(negedge clk);
        rx_a = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_dv_count",   dva_t.size(), 0);
        check("glitch_ferr_count", fea_t.size(), 0);
        check("glitch_rx_byte",    rx_byte_a,    8'h80);
        check("glitch_active_rises", acta_rise.size(), 1);
        if (acta_fall.size() > 0)
            check("glitch_active_fall", acta_fall[0], p + 3 + HALF_A);

        // Bad stop bit followed by a long break, then a good frame.
        clear_a();
        send(0, 8'h3C, 1'b0, p);
        repeat (5000) @(negedge clk);
        check("brk_ferr_count", fea_t.size(), 1);
        if (fea_t.size() > 0) check("brk_ferr_time", fea_t[0], p + LAT_A);
        check("brk_dv_count",   dva_t.size(),     0);
        check("brk_rx_byte",    rx_byte_a,        8'h80);
        check("brk_active_rises", acta_rise.size(), 1);
        check("brk_active_low", rx_active_a,      0);
        rx_a = 1'b1;
        repeat (2 * CPB_A) @(negedge clk);
        clear_a();
        send(0, 8'h5A, 1'b1, p2);
        repeat (CPB_A) @(negedge clk);
        check("post_brk_dv_count", dva_t.size(), 1);
        if (dva_t.size() > 0) begin
            check("post_brk_time", dva_t[0], p2 + LAT_A);
            check("post_brk_byte", dva_b[0], 8'h5A);
        end
        check("post_brk_ferr_count", fea_t.size(), 0);

        // Reset for 3 cycles in the middle of data bit 4 of 0x77.
        clear_a();
        fork
            send(0, 8'h77, 1'b1, p);
            begin
                repeat (5 * CPB_A + CPB_A / 2) @(negedge clk);
                rst_n_a = 1'b0;
                #1;
                check("midrst_dv",     rx_dv_a,     0);
                check("midrst_byte",   rx_byte_a,   0);
                check("midrst_active", rx_active_a, 0);
                check("midrst_ferr",   frame_err_a, 0);
                repeat (3) @(negedge clk);
                rst_n_a = 1'b1;
            end
        join
        repeat (2000) @(negedge clk);
        // The aborted frame yields nothing, but its low bit 7 after reset reads as a
        // fresh start bit; every later sample sees high, giving one 0xFF frame.
        check("midrst_dv_count", dva_t.size(), 1);
        if (dva_t.size() > 0) begin
            check("midrst_resync_time", dva_t[0], p + 8 * CPB_A + LAT_A);
            check("midrst_resync_byte", dva_b[0], 8'hFF);
        end
        check("midrst_ferr_count", fea_t.size(), 0);
        clear_a();
        send(0, 8'h12, 1'b1, p2);
        repeat (CPB_A) @(negedge clk);
        check("post_rst_dv_count", dva_t.size(), 1);
        if (dva_t.size() > 0) begin
            check("post_rst_time", dva_t[0], p2 + LAT_A);
            check("post_rst_byte", dva_b[0], 8'h12);
        end

        // Vector table on the fast receiver.
        for (int i = 0; i < 8; i++) begin
            clear_b();
            send(1, vecs[i].data, vecs[i].stop_ok, p);
            rx_b = 1'b1;
            repeat (3 * CPB_B) @(negedge clk);
            check($sformatf("vec%0d_dv_count", i),   dvb_t.size(), vecs[i].exp_dv);
            check($sformatf("vec%0d_ferr_count", i), feb_t.size(), vecs[i].exp_fe);
            check($sformatf("vec%0d_rx_byte", i),    rx_byte_b,    vecs[i].exp_byte);
            check($sformatf("vec%0d_active", i),     rx_active_b,  0);
            if (vecs[i].exp_dv != 0 && dvb_t.size() > 0)
                check($sformatf("vec%0d_dv_time", i), dvb_t[0], p + LAT_B);
            if (vecs[i].exp_fe != 0 && feb_t.size() > 0)
                check($sformatf("vec%0d_ferr_time", i), feb_t[0], p + LAT_B);
        end

        // Random loopback: model is the FIFO of bytes put on the line.
        clear_b();
        sent.delete();
        for (int i = 0; i < 256; i++) begin
            rb = 8'($urandom_range(0, 255));
            sent.push_back(rb);
            send(1, rb, 1'b1, p);
        end
        repeat (3 * CPB_B) @(negedge clk);
        check("loop_dv_count",   dvb_t.size(), 256);
        check("loop_ferr_count", feb_t.size(), 0);
        for (int i = 0; i < 256 && i < dvb_b.size(); i++)
            check($sformatf("loop_byte_%0d", i), dvb_b[i], sent[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
